// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : regfile_pkg                                                    |
// | Purpose   : Shared sizes and types for the ARM register-file write bank.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/decoder5_32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : decoder5_32                                                    |
// | Purpose   : 5-bit index to 32-bit one-hot decode, gated by an enable.      |
// |             Drives per-register write enables of a register-file write     |
// |             port; instantiated once per write port.                        |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module decoder5_32
    import regfile_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_idx,
    input  logic                  i_en,
    output logic [NUM_REGS-1:0]   o_onehot
);

    // One-hot of i_idx when enabled, all-zero otherwise.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule : decoder5_32
`default_nettype wire

// File: rtl/regfile_write_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : regfile_write_bank                                             |
// | Purpose   : 32 x 64-bit register array with one registered write port and  |
// |             a pending-write overlay so downstream read muxes never see     |
// |             stale data. The zero register reads as 0 and ignores writes.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module regfile_write_bank #(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         pend_vld,
    output logic [$clog2(NUM_REGS)-1:0]  pend_addr,
    output logic                         commit
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic              r_pend_vld;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;
    logic              r_commit;
    logic              w_accept;
    logic [NUM_REGS-1:0] w_we;
    logic [DATA_W-1:0] w_array [NUM_REGS];

    // A request aimed at the zero register is dropped at the door.
    assign w_accept = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

    // Pending stage: capture an accepted write; address reads 0 when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            r_pend_vld  <= w_accept;
            r_pend_addr <= w_accept ? wr_addr : '0;
            r_pend_data <= w_accept ? wr_data : '0;
        end
    end

    // Commit pulse marks the edge on which the pending write lands in the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_commit <= 1'b0;
        end else begin
            r_commit <= r_pend_vld;
        end
    end

    // Per-register load enables; also serve as the overlay select below.
    decoder5_32 u_wr_dec (
        .i_idx    (r_pend_addr),
        .i_en     (r_pend_vld),
        .o_onehot (w_we)
    );

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                assign w_array[gi] = '0;
            end else begin : g_flop
                logic [DATA_W-1:0] r_q;

                // Array entry: loads the pending data when its enable is decoded.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_q <= '0;
                    end else if (w_we[gi]) begin
                        r_q <= r_pend_data;
                    end
                end

                assign w_array[gi] = r_q;
            end

            // Pending data shadows the array entry it is about to overwrite.
            assign regs_flat[gi*DATA_W +: DATA_W] = w_we[gi] ? r_pend_data : w_array[gi];
        end
    endgenerate

    assign pend_vld  = r_pend_vld;
    assign pend_addr = r_pend_addr;
    assign commit    = r_commit;

endmodule : regfile_write_bank
`default_nettype wire

// File: tb/tb_regfile_write_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_regfile_write_bank                                          |
// | Purpose   : Scoreboard bench for regfile_write_bank. Stimulus updates an   |
// |             architectural model and queues the expected outputs; a monitor |
// |             pops and compares after every clock edge.                      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_regfile_write_bank;

    localparam int NR = 32;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int ZR = 31;

    typedef struct {
        logic          vld;
        logic [AW-1:0] addr;
        logic          commit;
        logic [NR*DW-1:0] regs;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic [NR*DW-1:0] regs_flat;
    logic             pend_vld;
    logic [AW-1:0]    pend_addr;
    logic             commit;

    int n_cmp = 0;
    int n_fail = 0;

    // Architectural model: what a reader should see after each edge.
    logic [DW-1:0] arch [NR];
    logic          prev_acc = 1'b0;
    exp_t          exp_q [$];

    regfile_write_bank dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .regs_flat (regs_flat),
        .pend_vld  (pend_vld),
        .pend_addr (pend_addr),
        .commit    (commit)
    );

    always #5 clk = ~clk;

    function automatic logic [NR*DW-1:0] model_regs();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = arch[i];
        return v;
    endfunction

    task automatic cmp_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cmp_regs(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            for (int i = 0; i < NR; i++) begin
                if (act[i*DW +: DW] !== req[i*DW +: DW]) begin
                    $display("FAIL %s: reg %0d got %h, expected %h (t=%0t)",
                             name, i, act[i*DW +: DW], req[i*DW +: DW], $time);
                    break;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus and queue what must be visible after the edge.
    task automatic step(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        logic acc;
        @(negedge clk);
        wr_en = en; wr_addr = a; wr_data = d;
        acc = en && (a != AW'(ZR));
        if (acc) arch[a] = d;
        e.vld    = acc;
        e.addr   = acc ? a : '0;
        e.commit = prev_acc;
        e.regs   = model_regs();
        exp_q.push_back(e);
        prev_acc = acc;
    endtask

    task automatic check_cleared(input string name);
        cmp_regs({name, "_regs"}, regs_flat, '0);
        cmp_val({name, "_pend_vld"}, DW'(pend_vld), '0);
        cmp_val({name, "_pend_addr"}, DW'(pend_addr), '0);
        cmp_val({name, "_commit"}, DW'(commit), '0);
    endtask

    // Assert reset between clock edges, check it acts at once, hold it while
    // wr_en toggles, then release and clear the model.
    task automatic async_reset(input int hold_cycles);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check_cleared("async_rst");
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            wr_en = ~wr_en; wr_addr = AW'($urandom_range(0, NR-1)); wr_data = {$urandom, $urandom};
            @(posedge clk);
            #1 check_cleared("rst_hold");
        end
        @(negedge clk);
        wr_en = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < NR; i++) arch[i] = '0;
        prev_acc = 1'b0;
    endtask

    // Monitor: after each edge compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp_val("pend_vld", DW'(pend_vld), DW'(e.vld));
                cmp_val("pend_addr", DW'(pend_addr), DW'(e.addr));
                cmp_val("commit", DW'(commit), DW'(e.commit));
                cmp_regs("regs_flat", regs_flat, e.regs);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NR; i++) arch[i] = '0;

        // Reset held from time 0 while wr_en toggles.
        #1 check_cleared("rst_init");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wr_en = ~wr_en; wr_addr = 5'd4; wr_data = 64'h1234;
            @(posedge clk);
            #1 check_cleared("rst_init_hold");
        end
        @(negedge clk);
        wr_en = 1'b0;
        reset_n = 1'b1;

        // Single write, then idle.
        step(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001);
        step(1'b0, 5'd0, 64'h0);
        step(1'b0, 5'd0, 64'h0);

        // Zero register write is discarded.
        step(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b0, 5'd0, 64'h0);
        step(1'b0, 5'd0, 64'h0);

        // Same address back-to-back.
        step(1'b1, 5'd7, 64'd1);
        step(1'b1, 5'd7, 64'd2);
        step(1'b0, 5'd0, 64'h0);
        step(1'b0, 5'd0, 64'h0);

        // Streaming writes on consecutive edges.
        for (int i = 0; i < 31; i++) step(1'b1, AW'(i), 64'(i) * 64'h0101);
        step(1'b0, 5'd0, 64'h0);
        step(1'b0, 5'd0, 64'h0);

        // Reset while a write is pending: it must never commit.
        step(1'b1, 5'd3, 64'd42);
        async_reset(2);
        for (int c = 0; c < 3; c++) step(1'b0, 5'd0, 64'h0);

        // Randomized traffic, including the zero register and repeated addresses.
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, NR-1)), {$urandom, $urandom});
        end
        step(1'b0, 5'd0, 64'h0);
        step(1'b0, 5'd0, 64'h0);

        // A second mid-run reset after random traffic, then a short tail.
        async_reset(1);
        for (int c = 0; c < 40; c++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR-1)), {$urandom, $urandom});
        end
        step(1'b0, 5'd0, 64'h0);

        @(posedge clk);
        #2;
        cmp_val("queue_drained", DW'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_regfile_write_bank
`default_nettype wire
